down_counter_sched: RTL and testbench

Scheduler that shares one `Down_Counter` instance between two requesters, each asking for a programmable countdown delay. It arbitrates round-robin, loads the winner's value through the counter's `latch`/`in` port, paces decrements on `dec` with a prescaler, watches `zero`, and returns a one-cycle `done` to the served requester. It sits between the requesting blocks and the `Down_Counter`; it is the only driver of the counter's control inputs.

---
 rtl/down_counter_sched.sv | 100 ++++++++++
 tb/tb_down_counter_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/down_counter_sched.sv
// down_counter_sched: shares one external down counter between two requesters.
// Round-robin arbitration, loads the winner's delay, paces decrements with a
// prescaler, and pulses done to the served requester when the count hits zero.
module down_counter_sched #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] val0,
    input  logic [WIDTH-1:0] val1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             gnt,
    output logic [WIDTH-1:0] ctr_in,
    output logic             ctr_latch,
    output logic             ctr_dec,
    input  logic             ctr_zero
);

    localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [PSC_W-1:0] psc;
    logic             last_gnt;
    logic             win;

    // Winner selection: a lone requester wins, a tie goes to the one not served last.
    assign win = (req0 && req1) ? ~last_gnt : req1;

    // Decrement only on the prescale boundary and never once the counter is at zero,
    // so the shared counter can never wrap below zero.
    assign ctr_dec = (state == COUNT) && (psc == PSC_MAX) && !ctr_zero;

    // Scheduler FSM with registered grant, load value and handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            psc       <= '0;
            last_gnt  <= 1'b1;
            gnt       <= 1'b0;
            ctr_in    <= '0;
            ctr_latch <= 1'b0;
            busy      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
        end else begin
            ctr_latch <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt       <= win;
                        ctr_in    <= win ? val1 : val0;
                        ctr_latch <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    psc   <= '0;
                    state <= COUNT;
                end
                COUNT: begin
                    if (ctr_zero) begin
                        done0 <= ~gnt;
                        done1 <= gnt;
                        psc   <= '0;
                        state <= DONE;
                    end else if (psc == PSC_MAX) begin
                        psc <= '0;
                    end else begin
                        psc <= psc + PSC_W'(1);
                    end
                end
                DONE: begin
                    last_gnt <= gnt;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_sched.sv
// Randomized bench for down_counter_sched: two instances (PRESCALE 1 and 3), each
// with a behavioural counter, autonomous random requesters and a timeline model.
module tb_down_counter_sched;

    localparam int unsigned W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int unsigned P = (g == 0) ? 1 : 3;
        localparam string ID = (g == 0) ? "p1 " : "p3 ";

        logic [1:0]   req;
        logic [W-1:0] val [2];
        logic         done0, done1, busy, gnt, ctr_latch, ctr_dec, ctr_zero;
        logic [W-1:0] ctr_in;
        logic [W-1:0] cnt;
        logic [1:0]   done_v;

        down_counter_sched #(.WIDTH(W), .PRESCALE(P)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .req0      (req[0]),
            .req1      (req[1]),
            .val0      (val[0]),
            .val1      (val[1]),
            .done0     (done0),
            .done1     (done1),
            .busy      (busy),
            .gnt       (gnt),
            .ctr_in    (ctr_in),
            .ctr_latch (ctr_latch),
            .ctr_dec   (ctr_dec),
            .ctr_zero  (ctr_zero)
        );

        // Shared down counter: latch wins over dec, no reset.
        always @(posedge clock) begin
            if (ctr_latch)    cnt <= ctr_in;
            else if (ctr_dec) cnt <= cnt - 1'b1;
        end
        assign ctr_zero = (cnt == '0);
        assign done_v   = {done1, done0};

        // Reference: one service is a timeline of N*P+3 cycles measured from the grant edge.
        bit           m_act, m_gnt, m_last;
        int           m_k, m_np;
        logic [W-1:0] m_in;

        always @(posedge clock or posedge reset) begin
            bit w;
            if (reset) begin
                m_act <= 0; m_gnt <= 0; m_last <= 1; m_k <= 0; m_np <= 0; m_in <= '0;
            end else if (m_act) begin
                if (m_k == m_np + 2) begin
                    m_act  <= 0;
                    m_last <= m_gnt;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (req[0] || req[1]) begin
                w = (req[0] && req[1]) ? !m_last : req[1];
                m_act <= 1;
                m_k   <= 0;
                m_gnt <= w;
                m_in  <= val[w];
                m_np  <= int'(val[w]) * int'(P);
            end
        end

        bit [1:0] pend;
        int       n_done;

        initial begin
            req = '0; val[0] = '0; val[1] = '0; pend = '0; n_done = 0;
        end

        // Per-cycle comparison against the model, then requester behaviour.
        always @(negedge clock) begin
            bit e_latch, e_done, e_dec;
            e_latch = m_act && (m_k == 0);
            e_done  = m_act && (m_k == m_np + 2);
            e_dec   = m_act && (m_k >= 1) && (m_k <= m_np) && ((m_k % int'(P)) == 0);
            check({ID, "busy"},  int'(busy),      int'(m_act));
            check({ID, "latch"}, int'(ctr_latch), int'(e_latch));
            check({ID, "dec"},   int'(ctr_dec),   int'(e_dec));
            check({ID, "done0"}, int'(done0),     int'(e_done && !m_gnt));
            check({ID, "done1"}, int'(done1),     int'(e_done && m_gnt));
            check({ID, "gnt"},   int'(gnt),       int'(m_gnt));
            check({ID, "ctr_in"}, int'(ctr_in),   int'(m_in));
            check({ID, "latch&dec"}, int'(ctr_latch && ctr_dec), 0);
            check({ID, "dec&zero"},  int'(ctr_dec && ctr_zero),  0);
            check({ID, "done0&done1"}, int'(done0 && done1), 0);
            if (m_act && m_k == 1) check({ID, "cnt@load"}, int'(cnt), int'(m_in));
            if (e_done) check({ID, "cnt@done"}, int'(cnt), 0);

            if (reset) begin
                req  = '0;
                pend = '0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (done_v[i]) begin
                        req[i]  = 1'b0;
                        pend[i] = 1'b0;
                        n_done++;
                    end else if (!pend[i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            case ($urandom_range(0, 3))
                                0:       val[i] = '0;
                                1:       val[i] = '1;
                                default: val[i] = W'($urandom_range(0, 15));
                            endcase
                            pend[i] = 1'b1;
                            req[i]  = 1'b1;
                        end
                    end else if (req[i] && busy && (int'(gnt) == i) && !ctr_latch &&
                                 $urandom_range(0, 15) == 0) begin
                        req[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (1500) @(negedge clock);

        // Interrupt the slow instance mid-countdown with an asynchronous reset.
        t = 0;
        while (!(inst[1].busy && !inst[1].ctr_latch && !inst[1].done0 && !inst[1].done1) && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("mid-count seen", int'(t < 200), 1);
        #2 reset = 1'b1;
        #1;
        check("rst busy",   int'(inst[1].busy),      0);
        check("rst latch",  int'(inst[1].ctr_latch), 0);
        check("rst dec",    int'(inst[1].ctr_dec),   0);
        check("rst done",   int'(inst[1].done0 || inst[1].done1), 0);
        check("rst gnt",    int'(inst[1].gnt),       0);
        check("rst ctr_in", int'(inst[1].ctr_in),    0);
        check("rst busy p1", int'(inst[0].busy),     0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (1500) @(negedge clock);

        check("p1 services", int'(inst[0].n_done >= 20), 1);
        check("p3 services", int'(inst[1].n_done >= 20), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
